// File: rtl/systolic_feeder_if.sv
// Operand-load and skewed-stream signals between a controller and the
// systolic_feeder. The controller is the master; the feeder is the slave.
interface systolic_feeder_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                  wr_en;
  logic                  wr_sel;
  logic [IW-1:0]         wr_row;
  logic [IW-1:0]         wr_col;
  logic signed [7:0]     wr_data;
  logic                  start;
  logic [N*8-1:0]        a_row;
  logic [N*8-1:0]        b_col;
  logic [N-1:0]          valid_row;
  logic [N-1:0]          valid_col;
  logic                  busy;
  logic                  done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_row, b_col, valid_row, valid_col, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_row, b_col, valid_row, valid_col, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic array operand feeder: holds an N x N A matrix and an N x N B
// matrix and, on start, streams them diagonally skewed so that row lane i
// carries A[i][t-i] and column lane j carries B[t-j][j] on step t.
// Outputs are registered from next-state values, so step 0 is visible in
// the cycle right after the start edge, and a write issued together with
// start is forwarded into that first step.
module systolic_feeder #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  systolic_feeder_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int TW     = (N > 1) ? $clog2(2 * N) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                   state, state_nx;
  logic [TW-1:0]            t, t_nx;
  logic signed [DATA_W-1:0] a_mem [N][N];
  logic signed [DATA_W-1:0] b_mem [N][N];
  logic signed [DATA_W-1:0] a_nx  [N][N];
  logic signed [DATA_W-1:0] b_nx  [N][N];
  logic signed [DATA_W-1:0] a_lane_nx [N];
  logic signed [DATA_W-1:0] b_lane_nx [N];
  logic [N-1:0]             vr_nx, vc_nx;
  logic                     row_ok, col_ok, wr_ok;

  // Next state and step counter: IDLE -> STREAM (2N-1 steps) -> FINISH -> IDLE
  always_comb begin
    state_nx = state;
    t_nx     = t;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = STREAM;
          t_nx     = '0;
        end
      end
      STREAM: begin
        if (t == T_LAST) begin
          state_nx = FINISH;
          t_nx     = '0;
        end else begin
          t_nx = t + 1'b1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
    endcase
  end

  // Write qualification: only in IDLE, and indices beyond N are dropped
  always_comb begin
    row_ok = 1'b0;
    col_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.wr_row == IW'(k)) row_ok = 1'b1;
      if (bus.wr_col == IW'(k)) col_ok = 1'b1;
    end
    wr_ok = bus.wr_en && row_ok && col_ok && (state == IDLE);
  end

  // Matrix contents after this edge's write, so a same-cycle start sees it
  always_comb begin
    a_nx = a_mem;
    b_nx = b_mem;
    if (wr_ok) begin
      if (bus.wr_sel) b_nx[bus.wr_row][bus.wr_col] = bus.wr_data;
      else            a_nx[bus.wr_row][bus.wr_col] = bus.wr_data;
    end
  end

  // Diagonal skew: lane i is live while 0 <= t-i <= N-1, zero otherwise
  always_comb begin
    vr_nx = '0;
    vc_nx = '0;
    for (int i = 0; i < N; i++) begin
      a_lane_nx[i] = '0;
      b_lane_nx[i] = '0;
    end
    if (state_nx == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_nx) == i + k) begin
            a_lane_nx[i] = a_nx[i][k];
            b_lane_nx[i] = b_nx[k][i];
            vr_nx[i]     = 1'b1;
            vc_nx[i]     = 1'b1;
          end
        end
      end
    end
  end

  // State, storage and registered outputs; reset aborts and clears everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      t             <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
      bus.a_row     <= '0;
      bus.b_col     <= '0;
      bus.valid_row <= '0;
      bus.valid_col <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nx;
      t             <= t_nx;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= a_nx[r][c];
          b_mem[r][c] <= b_nx[r][c];
        end
      end
      for (int i = 0; i < N; i++) begin
        bus.a_row[DATA_W*i +: DATA_W] <= a_lane_nx[i];
        bus.b_col[DATA_W*i +: DATA_W] <= b_lane_nx[i];
      end
      bus.valid_row <= vr_nx;
      bus.valid_col <= vc_nx;
      bus.busy      <= (state_nx == STREAM);
      bus.done      <= (state_nx == FINISH);
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder (N=4). Stimulus pushes expected per-cycle
// outputs (with the cycle they must appear in) into a queue; a monitor on
// the falling edge pops one entry whenever busy or done is high and checks
// that outputs are all zero otherwise.
module tb_systolic_feeder;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N)) sf_if ();
  systolic_feeder #(.N(N)) dut (.clk(clk), .reset(reset), .bus(sf_if));

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  vr;
    logic [3:0]  vc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Hand-computed stream for A[r][c]=4r+c+1, B[r][c]=-(4r+c+1), steps t=0..6
  logic [31:0] a_tab [7] = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
                             32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
  logic [31:0] b_tab [7] = '{32'h000000FF, 32'h0000FEFB, 32'h00FDFAF7, 32'hFCF9F6F3,
                             32'hF8F5F200, 32'hF4F10000, 32'hF0000000};
  logic [3:0]  v_tab [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // kind 0: base matrices, 1: A[0][0]=-128, 2: all zero. c0 = cycle of start edge minus one.
  task automatic push_stream(input int kind, input int n, input int c0);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = c0 + 1 + k;
      e.a    = (kind == 2) ? 32'h0 : a_tab[k];
      if (kind == 1 && k == 0) e.a = 32'h00000080;
      e.b    = (kind == 2) ? 32'h0 : b_tab[k];
      e.vr   = v_tab[k];
      e.vc   = v_tab[k];
      e.busy = 1'b1;
      e.done = 1'b0;
      q.push_back(e);
    end
    if (n == 7) begin
      e.cyc  = c0 + 8;
      e.a    = '0;
      e.b    = '0;
      e.vr   = '0;
      e.vc   = '0;
      e.busy = 1'b0;
      e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  // Monitor: compare against the queue whenever the DUT is presenting a stream
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sf_if.busy || sf_if.done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got busy=%b done=%b a=%h b=%h, required no activity",
                   cyc, sf_if.busy, sf_if.done, sf_if.a_row, sf_if.b_col);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || sf_if.a_row !== e.a || sf_if.b_col !== e.b ||
              sf_if.valid_row !== e.vr || sf_if.valid_col !== e.vc ||
              sf_if.busy !== e.busy || sf_if.done !== e.done) begin
            errors++;
            $display("FAIL stream cyc=%0d a=%h b=%h vr=%h vc=%h busy=%b done=%b | required cyc=%0d a=%h b=%h vr=%h vc=%h busy=%b done=%b",
                     cyc, sf_if.a_row, sf_if.b_col, sf_if.valid_row, sf_if.valid_col,
                     sf_if.busy, sf_if.done, e.cyc, e.a, e.b, e.vr, e.vc, e.busy, e.done);
          end
        end
      end else begin
        checks++;
        if (sf_if.a_row !== '0 || sf_if.b_col !== '0 || sf_if.valid_row !== '0 ||
            sf_if.valid_col !== '0 || sf_if.busy !== 1'b0 || sf_if.done !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d a=%h b=%h vr=%h vc=%h busy=%b done=%b, required all 0",
                   cyc, sf_if.a_row, sf_if.b_col, sf_if.valid_row, sf_if.valid_col,
                   sf_if.busy, sf_if.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic wr(input logic sel, input int r, input int c, input logic signed [7:0] d);
    sf_if.wr_en   = 1'b1;
    sf_if.wr_sel  = sel;
    sf_if.wr_row  = 2'(r);
    sf_if.wr_col  = 2'(c);
    sf_if.wr_data = d;
    @(posedge clk);
    #1;
    sf_if.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    sf_if.start = 1'b1;
    @(posedge clk);
    #1;
    sf_if.start = 1'b0;
  endtask

  // Full stream; returns in the IDLE cycle following FINISH
  task automatic run_stream(input int kind);
    push_stream(kind, 7, cyc);
    pulse_start();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_row"},     64'(sf_if.a_row),     64'h0);
    chk({tag, "_b_col"},     64'(sf_if.b_col),     64'h0);
    chk({tag, "_valid_row"}, 64'(sf_if.valid_row), 64'h0);
    chk({tag, "_valid_col"}, 64'(sf_if.valid_col), 64'h0);
    chk({tag, "_busy"},      64'(sf_if.busy),      64'h0);
    chk({tag, "_done"},      64'(sf_if.done),      64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    sf_if.wr_en   = 1'b0;
    sf_if.wr_sel  = 1'b0;
    sf_if.wr_row  = '0;
    sf_if.wr_col  = '0;
    sf_if.wr_data = '0;
    sf_if.start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load A[r][c]=4r+c+1 and B[r][c]=-(4r+c+1)
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 8'(4 * r + c + 1));
        wr(1'b1, r, c, 8'(-(4 * r + c + 1)));
      end
    end

    // Stream with a write and a start attempted mid-stream: both ignored
    push_stream(0, 7, cyc);
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    sf_if.wr_en   = 1'b1;
    sf_if.wr_sel  = 1'b0;
    sf_if.wr_row  = 2'd0;
    sf_if.wr_col  = 2'd0;
    sf_if.wr_data = 8'sd99;
    sf_if.start   = 1'b1;
    @(posedge clk);
    #1;
    sf_if.wr_en   = 1'b0;
    sf_if.start   = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Re-stream without writes, then back-to-back pair
    run_stream(0);
    run_stream(0);
    run_stream(0);

    // Start held high across two streams
    push_stream(0, 7, cyc);
    push_stream(0, 7, cyc + 9);
    sf_if.start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sf_if.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Write and start in the same IDLE cycle: new value streams at once
    push_stream(1, 7, cyc);
    sf_if.wr_en   = 1'b1;
    sf_if.wr_sel  = 1'b0;
    sf_if.wr_row  = 2'd0;
    sf_if.wr_col  = 2'd0;
    sf_if.wr_data = -8'sd128;
    sf_if.start   = 1'b1;
    @(posedge clk);
    #1;
    sf_if.wr_en   = 1'b0;
    sf_if.start   = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset during streaming cycle 3: outputs clear at once, no done
    push_stream(1, 3, cyc);
    pulse_start();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Matrices were cleared by reset: stream carries zeros with normal valids
    run_stream(2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
